// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Source end of the VGA pipeline bus. Free-running horizontal/vertical
//   counters with blanking and sync decode for 1024x768@60 Hz (65 MHz pixel
//   clock), packed onto the VGA bus that feeds every downstream draw stage.
//
//   Optional feature (compile-time macro VGA_TEST_PATTERN_EN):
//     defined   -> rgb carries 8 vertical colour bars of width H_ACTIVE/8,
//                  forced to black during blanking
//     undefined -> rgb is constant 12'h000 and no pattern logic exists
//
// Ports
//   clk          pixel clock
//   rst          asynchronous reset, active low (asserted at 0)
//   en           count enable; every bus field holds while low
//   vga_out      packed bus {vcount[11:0], hcount[11:0], vs, vblnk, hs,
//                hblnk, rgb[11:0]} (VGA_BUS_SIZE = 40 bits)
//   frame_start  one-cycle pulse in the cycle the counters become (0,0)
// ---------------------------------------------------------------------------

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 40
`endif

`ifndef VGA_MERGE
`define VGA_MERGE(vc, hc, vsy, vbl, hsy, hbl, col) {vc, hc, vsy, vbl, hsy, hbl, col}
`endif

module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [`VGA_BUS_SIZE-1:0] vga_out,
  output logic                     frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows, inclusive bounds
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [11:0] hcount_reg, hcount_next;
  logic [11:0] vcount_reg, vcount_next;
  logic        hblnk_reg, hblnk_next;
  logic        vblnk_reg, vblnk_next;
  logic        hs_reg, hs_next;
  logic        vs_reg, vs_next;
  logic        frame_start_reg, frame_start_next;
  logic [11:0] rgb;

  // Next-state counters. With en low the next state equals the current
  // state, so every decoded flag below re-evaluates to its held value.
  always_comb begin
    hcount_next = hcount_reg;
    vcount_next = vcount_reg;
    if (en) begin
      if (hcount_reg == 12'(HT - 1)) begin
        hcount_next = 12'd0;
        if (vcount_reg == 12'(VT - 1)) begin
          vcount_next = 12'd0;
        end else begin
          vcount_next = vcount_reg + 12'd1;
        end
      end else begin
        hcount_next = hcount_reg + 12'd1;
      end
    end
  end

  // Flags decode the next-state counts so that, once registered, they line
  // up with the counts of the same pixel.
  always_comb begin
    hblnk_next = (hcount_next >= 12'(H_ACTIVE));
    vblnk_next = (vcount_next >= 12'(V_ACTIVE));
    hs_next    = ((hcount_next >= 12'(HS_FIRST)) && (hcount_next <= 12'(HS_LAST)))
                 ? SYNC_POL : ~SYNC_POL;
    vs_next    = ((vcount_next >= 12'(VS_FIRST)) && (vcount_next <= 12'(VS_LAST)))
                 ? SYNC_POL : ~SYNC_POL;
    // Only the true end-of-frame wrap produces the pulse; a hold never does.
    frame_start_next = en && (hcount_reg == 12'(HT - 1)) && (vcount_reg == 12'(VT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_reg      <= 12'd0;
      vcount_reg      <= 12'd0;
      hblnk_reg       <= 1'b0;
      vblnk_reg       <= 1'b0;
      hs_reg          <= ~SYNC_POL;
      vs_reg          <= ~SYNC_POL;
      frame_start_reg <= 1'b0;
    end else begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      hblnk_reg       <= hblnk_next;
      vblnk_reg       <= vblnk_next;
      hs_reg          <= hs_next;
      vs_reg          <= vs_next;
      frame_start_reg <= frame_start_next;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb_reg, rgb_next;

  // Bar index is hcount[9:7]: eight bars of 128 pixels across 1024.
  always_comb begin
    rgb_next = 12'h000;
    if (!hblnk_next && !vblnk_next) begin
      case (hcount_next[9:7])
        3'd0:    rgb_next = 12'hFFF;
        3'd1:    rgb_next = 12'hFF0;
        3'd2:    rgb_next = 12'h0FF;
        3'd3:    rgb_next = 12'h0F0;
        3'd4:    rgb_next = 12'hF0F;
        3'd5:    rgb_next = 12'hF00;
        3'd6:    rgb_next = 12'h00F;
        default: rgb_next = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_reg <= 12'h000;
    end else begin
      rgb_reg <= rgb_next;
    end
  end

  assign rgb = rgb_reg;
`else
  assign rgb = 12'h000;
`endif

  assign vga_out     = `VGA_MERGE(vcount_reg, hcount_reg, vs_reg, vblnk_reg,
                                  hs_reg, hblnk_reg, rgb);
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Instance A: default 1024x768 timing, directed scenarios.
//   Instance B: tiny timing (25 x 13, SYNC_POL=1) with random enable, so many
//   complete frames and wraps fit in a short run.
//   The reference tracks each instance as a single linear pixel index and
//   derives every bus field from it arithmetically.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int A_HA = 1024, A_HF = 24, A_HS = 136, A_HB = 160;
  localparam int A_VA = 768,  A_VF = 3,  A_VS = 6,   A_VB = 29;
  localparam int A_TOT = 1344 * 806;

  localparam int B_HA = 16, B_HF = 2, B_HS = 4, B_HB = 3;
  localparam int B_VA = 8,  B_VF = 1, B_VS = 2, B_VB = 2;
  localparam int B_TOT = 25 * 13;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        en_a = 1'b1, en_b = 1'b1;
  logic [39:0] bus_a, bus_b;
  logic        fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .vga_out(bus_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .vga_out(bus_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  // Expected bus for linear pixel index p under the given timing.
  function automatic logic [39:0] exp_bus(int p, int ha, int hf, int hsw, int hb,
                                          int va, int vf, int vsw, int vb, bit pol);
    int ht, h, v;
    logic hs, vs, hbl, vbl;
    logic [11:0] rgb;
    logic [11:0] hv;
    logic [11:0] colors [8];
    ht  = ha + hf + hsw + hb;
    h   = p % ht;
    v   = p / ht;
    hbl = (h >= ha);
    vbl = (v >= va);
    hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
    vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
    hv  = 12'(h);
    colors = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    rgb = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (!hbl && !vbl) rgb = colors[hv[9:7]];
`endif
    if (vb < 0) rgb = colors[0];  // never true; keeps colors referenced
    return {12'(v), hv, vs, vbl, hs, hbl, rgb};
  endfunction

  // Reference: linear position advances by one per enabled edge.
  int pa = 0, pb = 0;
  bit mfs_a = 0, mfs_b = 0;
  int en_edges_b = 0;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      pa <= 0; mfs_a <= 0;
    end else if (en_a) begin
      pa <= (pa + 1) % A_TOT; mfs_a <= (pa == A_TOT - 1);
    end else begin
      mfs_a <= 0;
    end
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pb <= 0; mfs_b <= 0;
    end else if (en_b) begin
      pb <= (pb + 1) % B_TOT; mfs_b <= (pb == B_TOT - 1);
      en_edges_b <= en_edges_b + 1;
    end else begin
      mfs_b <= 0;
    end
  end

  // Compare process: every cycle, both instances.
  int last_pulse_b = 0;
  bit seen_pulse_b = 0;
  int pulses_b = 0;
  always @(negedge clk) begin
    logic [39:0] ea, eb;
    ea = exp_bus(pa, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0);
    eb = exp_bus(pb, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1);
    checks += 4;
    if (bus_a !== ea) begin
      errors++; $display("FAIL bus_a t=%0t got=%h exp=%h", $time, bus_a, ea);
    end
    if (fs_a !== mfs_a) begin
      errors++; $display("FAIL fs_a t=%0t got=%b exp=%b", $time, fs_a, mfs_a);
    end
    if (bus_b !== eb) begin
      errors++; $display("FAIL bus_b t=%0t got=%h exp=%h", $time, bus_b, eb);
    end
    if (fs_b !== mfs_b) begin
      errors++; $display("FAIL fs_b t=%0t got=%b exp=%b", $time, fs_b, mfs_b);
    end
    // Literal pin: 325 enabled edges between consecutive pulses of B.
    if (fs_b === 1'b1) begin
      pulses_b++;
      if (seen_pulse_b) begin
        checks++;
        if (en_edges_b - last_pulse_b != 325) begin
          errors++;
          $display("FAIL period_b got=%0d exp=325", en_edges_b - last_pulse_b);
        end
      end
      seen_pulse_b = 1;
      last_pulse_b = en_edges_b;
    end
  end

  // Random enable for B throughout the run.
  initial begin
    forever begin
      @(negedge clk);
      en_b = ($urandom_range(0, 7) != 0);
    end
  end

  task automatic check_lit(string name, logic [39:0] got, logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
    else $display("check %s ok value=%h", name, got);
  endtask

  // Advance A (at negedges) until it shows (v,h); bounded.
  task automatic run_until_a(int h, int v, bit rand_en, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_a[27:16] == 12'(h) && bus_a[39:28] == 12'(v)) return;
      en_a = rand_en ? ($urandom_range(0, 9) != 0) : 1'b1;
    end
    checks++; errors++;
    $display("FAIL timeout_a waiting for v=%0d h=%0d got=%h", v, h, bus_a);
  endtask

  initial begin
    int hs_low, hbl_cnt;
    logic [39:0] cap;
    #2;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (700) @(negedge clk);

    // Mid-frame asynchronous reset: outputs clear without a clock edge.
    #3 rst_a = 1'b0;
    #1 check_lit("async_reset_bus", bus_a, 40'h000000A000);
    check_lit("async_reset_fs", {39'd0, fs_a}, 40'd0);
    @(negedge clk);
    rst_a = 1'b1; en_a = 1'b1;
    @(negedge clk);
    check_lit("first_edge_pos", {bus_a[39:16], 15'd0, fs_a}, {12'd0, 12'd1, 16'd0});

    // Line 0 scan, h = 1..1343 with steady enable.
    hs_low = 0; hbl_cnt = 0;
    for (int i = 0; i < 1343; i++) begin
      if (bus_a[13] == 1'b0) hs_low++;
      if (bus_a[12] == 1'b1) hbl_cnt++;
`ifdef VGA_TEST_PATTERN_EN
      if (bus_a[27:16] == 12'd128) check_lit("rgb_h128", {28'd0, bus_a[11:0]}, 40'hFF0);
      if (bus_a[27:16] == 12'd1023) check_lit("rgb_h1023", {28'd0, bus_a[11:0]}, 40'h000);
`endif
      @(negedge clk);
    end
    check_lit("hs_low_count", 40'(hs_low), 40'd136);
    check_lit("hblnk_count", 40'(hbl_cnt), 40'd320);
    check_lit("line1_start", {bus_a[39:16], 16'd0}, {12'd1, 12'd0, 16'd0});

    // Hold for 50 cycles at hcount 500.
    run_until_a(500, 1, 1'b1, 4000);
    en_a = 1'b0;
    cap = bus_a;
    repeat (50) begin
      @(negedge clk);
      check_lit("hold_bus", bus_a, cap);
      check_lit("hold_fs", {39'd0, fs_a}, 40'd0);
    end
    en_a = 1'b1;
    @(negedge clk);
    check_lit("resume_h501", {28'd0, bus_a[27:16]}, 40'd501);

    // Line wrap from (10,1343) to (11,0) under random enable.
    run_until_a(1343, 10, 1'b1, 20000);
    en_a = 1'b1;
    @(negedge clk);
    check_lit("line_wrap", {bus_a[39:16], 16'd0}, {12'd11, 12'd0, 16'd0});

    checks++;
    if (pulses_b < 10) begin
      errors++; $display("FAIL pulses_b got=%0d exp>=10", pulses_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
